xoodoo_perm_ctrl: RTL and testbench

XOODOO_PERM_CTRL -- requirements
Module: xoodoo_perm_ctrl

---
 rtl/xoodoo_perm_ctrl.sv | 119 +++++++++++
 tb/tb_xoodoo_perm_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/xoodoo_perm_ctrl.sv
// Round sequencer for a masked Xoodoo permutation: walks the one-hot round-constant
// selector and gates the two randomness loads (share 0, then share 1) of every round.
//   state | meaning
//   IDLE  | waiting for start; illegal round counts answered with err
//   LOAD  | round datapath takes the external shares
//   P0    | waiting for randomness for the share-0 mask register
//   P1    | waiting for randomness for the share-1 mask register; round completes
//   FIN   | output shares final, done pulse
module xoodoo_perm_ctrl #(
   parameter int MAX_ROUNDS = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [3:0]            n_rounds,
   input  logic                  rnd_valid,
   output logic                  rnd_ready,
   output logic                  rdi0_en,
   output logic                  rdi1_en,
   output logic                  load_sel,
   output logic [MAX_ROUNDS:0]   j_out,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int JW = MAX_ROUNDS + 1;
   localparam logic [4:0] MAX_R = 5'(MAX_ROUNDS);

   typedef enum logic [2:0] {IDLE, LOAD, P0, P1, FIN} state_t;

   state_t        state_q;
   logic [JW-1:0] j_q;
   logic [3:0]    cnt_q;
   logic          busy_q, load_sel_q, rnd_ready_q, p0_q, p1_q, done_q, err_q;
   logic          n_ok;

   assign n_ok = (n_rounds != 4'd0) && ({1'b0, n_rounds} <= MAX_R);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         j_q         <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         load_sel_q  <= 1'b0;
         rnd_ready_q <= 1'b0;
         p0_q        <= 1'b0;
         p1_q        <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  if (n_ok) begin
                     // j and the counter are set on entry so j_out is valid during LOAD
                     state_q    <= LOAD;
                     busy_q     <= 1'b1;
                     load_sel_q <= 1'b1;
                     j_q        <= JW'(1) << (MAX_R - {1'b0, n_rounds});
                     cnt_q      <= n_rounds;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            LOAD: begin
               state_q     <= P0;
               load_sel_q  <= 1'b0;
               rnd_ready_q <= 1'b1;
               p0_q        <= 1'b1;
            end
            P0: begin
               if (rnd_valid) begin
                  state_q <= P1;
                  p0_q    <= 1'b0;
                  p1_q    <= 1'b1;
               end
            end
            P1: begin
               if (rnd_valid) begin
                  cnt_q <= cnt_q - 4'd1;
                  p1_q  <= 1'b0;
                  if (cnt_q == 4'd1) begin
                     // last round: j stops at bit MAX_ROUNDS-1 and is cleared, never shifted
                     state_q     <= FIN;
                     j_q         <= '0;
                     rnd_ready_q <= 1'b0;
                     done_q      <= 1'b1;
                  end else begin
                     state_q <= P0;
                     j_q     <= j_q << 1;
                     p0_q    <= 1'b1;
                  end
               end
            end
            FIN: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               j_q     <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rnd_ready = rnd_ready_q;
   assign rdi0_en   = p0_q & rnd_valid;
   assign rdi1_en   = p1_q & rnd_valid;
   assign load_sel  = load_sel_q;
   assign j_out     = j_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_xoodoo_perm_ctrl.sv
// Directed bench for xoodoo_perm_ctrl: full/short runs, randomness stall, illegal
// round counts, mid-run reset and ignored re-starts, checked cycle by cycle.
module tb_xoodoo_perm_ctrl;
   localparam int MAXR = 12;

   logic            clk = 1'b0;
   logic            rst, start, rnd_valid;
   logic [3:0]      n_rounds;
   logic            rnd_ready, rdi0_en, rdi1_en, load_sel, busy, done, err;
   logic [MAXR:0]   j_out;
   int              n_checks = 0;
   int              n_pass = 0;

   always #5 clk = ~clk;

   xoodoo_perm_ctrl #(.MAX_ROUNDS(MAXR)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .n_rounds  (n_rounds),
      .rnd_valid (rnd_valid),
      .rnd_ready (rnd_ready),
      .rdi0_en   (rdi0_en),
      .rdi1_en   (rdi1_en),
      .load_sel  (load_sel),
      .j_out     (j_out),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, ".busy"},      16'(busy),      16'h0);
      check({tag, ".load_sel"},  16'(load_sel),  16'h0);
      check({tag, ".rnd_ready"}, 16'(rnd_ready), 16'h0);
      check({tag, ".rdi0"},      16'(rdi0_en),   16'h0);
      check({tag, ".rdi1"},      16'(rdi1_en),   16'h0);
      check({tag, ".j_out"},     16'(j_out),     16'h0);
      check({tag, ".done"},      16'(done),      16'h0);
   endtask

   // One permutation started in cycle 0. Randomness is withheld for stall_l cycles
   // starting at cycle stall_s; during that window the timeline is frozen.
   task automatic run(input int n, input int stall_s, input int stall_l, input bit restart,
                      input int want_done, input string nm);
      int done_c = -1;
      int e, r;
      bit v, is_load, is_p0, is_p1, is_fin;
      logic [MAXR:0] j_exp;
      int limit = 2 * n + 2 + stall_l + 3;
      for (int c = 0; c <= limit; c++) begin
         start     = (c == 0) || (restart && (c == 3 || c == 10));
         n_rounds  = (c == 0) ? 4'(n) : 4'd5;
         v         = !(c >= stall_s && c < stall_s + stall_l);
         rnd_valid = v;
         @(negedge clk);
         e = (c < stall_s) ? c : ((c < stall_s + stall_l) ? stall_s : c - stall_l);
         is_load = (e == 1);
         is_p0   = (e >= 2) && (e <= 2 * n + 1) && (e % 2 == 0);
         is_p1   = (e >= 2) && (e <= 2 * n + 1) && (e % 2 == 1);
         is_fin  = (e == 2 * n + 2);
         r       = e / 2;
         j_exp   = '0;
         if (is_load) j_exp = (MAXR + 1)'(1) << (MAXR - n);
         if (is_p0 || is_p1) j_exp = (MAXR + 1)'(1) << (MAXR - n + r - 1);
         check({nm, ".busy"},      16'(busy),      16'(is_load || is_p0 || is_p1 || is_fin));
         check({nm, ".load_sel"},  16'(load_sel),  16'(is_load));
         check({nm, ".rnd_ready"}, 16'(rnd_ready), 16'(is_p0 || is_p1));
         check({nm, ".rdi0"},      16'(rdi0_en),   16'(is_p0 && v));
         check({nm, ".rdi1"},      16'(rdi1_en),   16'(is_p1 && v));
         check({nm, ".done"},      16'(done),      16'(is_fin));
         check({nm, ".err"},       16'(err),       16'h0);
         if (!is_fin) check({nm, ".j_out"}, 16'(j_out), 16'(j_exp));
         if (done === 1'b1 && done_c < 0) done_c = c;
         next_cyc();
      end
      start     = 1'b0;
      rnd_valid = 1'b1;
      check({nm, ".done_cycle"}, 16'(done_c), 16'(want_done));
   endtask

   task automatic bad_start(input logic [3:0] n, input string nm);
      start     = 1'b1;
      n_rounds  = n;
      @(negedge clk);
      check({nm, ".err_early"}, 16'(err), 16'h0);
      next_cyc();
      start = 1'b0;
      @(negedge clk);
      check({nm, ".err"}, 16'(err), 16'h1);
      check_quiet(nm);
      next_cyc();
      @(negedge clk);
      check({nm, ".err_pulse"}, 16'(err), 16'h0);
      check({nm, ".busy_after"}, 16'(busy), 16'h0);
      next_cyc();
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b1;
      n_rounds  = 4'd12;
      rnd_valid = 1'b1;
      next_cyc();
      next_cyc();
      @(negedge clk);
      check_quiet("reset");
      check("reset.err", 16'(err), 16'h0);
      next_cyc();
      rst   = 1'b0;
      start = 1'b0;
      next_cyc();

      run(12, 1000, 0, 1'b0, 26, "full12");
      run(6,  1000, 0, 1'b0, 14, "short6");
      run(1,  1000, 0, 1'b0, 4,  "single1");
      run(12, 9,    3, 1'b0, 29, "stall_r4");
      run(12, 4,    2, 1'b0, 28, "stall_p0r2");
      run(12, 1000, 0, 1'b1, 26, "restart");

      bad_start(4'd0,  "bad0");
      bad_start(4'd13, "bad13");
      bad_start(4'd15, "bad15");

      // reset in round 7, P0 at cycle 14
      start     = 1'b1;
      n_rounds  = 4'd12;
      rnd_valid = 1'b1;
      next_cyc();
      start = 1'b0;
      for (int c = 1; c < 14; c++) next_cyc();
      @(negedge clk);
      check("rst7.j_before", 16'(j_out), 16'h040);
      rst = 1'b1;
      next_cyc();
      rst = 1'b0;
      @(negedge clk);
      check_quiet("rst7");
      begin
         int seen_done = 0;
         for (int c = 0; c < 30; c++) begin
            next_cyc();
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done++;
         end
         check("rst7.no_activity", 16'(seen_done), 16'h0);
      end
      next_cyc();

      // start together with rst is ignored
      rst      = 1'b1;
      start    = 1'b1;
      n_rounds = 4'd12;
      next_cyc();
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check_quiet("rst_start");
      next_cyc();
      @(negedge clk);
      check("rst_start.busy2", 16'(busy), 16'h0);
      next_cyc();

      run(12, 1000, 0, 1'b0, 26, "after_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
